// File: rtl/multicycle_control.sv
// multicycle_control: control FSM for a multicycle LEGv8-style datapath.
// Sequences FETCH -> DECODE -> EXEC -> MEM -> WB per instruction class,
// counts retired instructions and times out stalled data-memory accesses.
// Optional build macro: ILLEGAL_OP_TRAP_EN (illegal opcodes enter a sticky
// TRAP state instead of retiring as a NOP).
module multicycle_control #(
  parameter int CNT_W  = 16,
  parameter int MEM_TO = 8
) (
  input  logic             CLK,
  input  logic             resetl,
  input  logic [10:0]      Opcode,
  input  logic             mem_ready,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic             Uncondbranch,
  output logic [1:0]       ALUOp,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             mem_err,
  output logic             trap
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_ILLEGAL = 4'd0,
    C_LDUR    = 4'd1,
    C_STUR    = 4'd2,
    C_ADD     = 4'd3,
    C_SUB     = 4'd4,
    C_AND     = 4'd5,
    C_ORR     = 4'd6,
    C_CBZ     = 4'd7,
    C_B       = 4'd8
  } cls_t;

  // Instruction-class decode of opcode bits [31:21]; anything unmatched is illegal.
  function automatic cls_t decode_op(input logic [10:0] op);
    cls_t c;
    c = C_ILLEGAL;
    casez (op)
      11'b11111000010: c = C_LDUR;
      11'b11111000000: c = C_STUR;
      11'b10001011000: c = C_ADD;
      11'b11001011000: c = C_SUB;
      11'b10001010000: c = C_AND;
      11'b10101010000: c = C_ORR;
      11'b10110100???: c = C_CBZ;
      11'b000101?????: c = C_B;
      default:         c = C_ILLEGAL;
    endcase
    return c;
  endfunction

  state_t     st_q;
  state_t     st_d;
  cls_t       cls_q;
  cls_t       dec_cls;
  logic [7:0] wcnt_q;
  logic       mem_last;
  logic       retire;

  assign dec_cls  = decode_op(Opcode);
  // Last permitted wait cycle: a not-ready access here times out.
  assign mem_last = (wcnt_q == 8'(MEM_TO - 1));
  assign state    = st_q;

`ifdef ILLEGAL_OP_TRAP_EN
  assign trap = (st_q == S_TRAP);
`else
  assign trap = 1'b0;
`endif

  // State register; reset drops straight back to FETCH even mid-access.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      st_q <= S_FETCH;
    end else begin
      st_q <= st_d;
    end
  end

  // Instruction class captured at the end of DECODE and held for the rest of the instruction.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      cls_q <= C_ILLEGAL;
    end else if (st_q == S_DECODE) begin
      cls_q <= dec_cls;
    end
  end

  // Memory wait counter: zero outside MEM, counts not-ready MEM cycles.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      wcnt_q <= '0;
    end else if (st_q != S_MEM) begin
      wcnt_q <= '0;
    end else if (!mem_ready) begin
      wcnt_q <= wcnt_q + 8'd1;
    end
  end

  // Retired-instruction counter; wraps silently at 2^CNT_W.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      retired <= '0;
    end else if (retire) begin
      retired <= retired + CNT_W'(1);
    end
  end

  // Next-state and datapath control decode; every output defaults to 0.
  always_comb begin
    st_d         = S_FETCH;
    Reg2Loc      = 1'b0;
    ALUSrc       = 1'b0;
    MemToReg     = 1'b0;
    RegWrite     = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    Branch       = 1'b0;
    Uncondbranch = 1'b0;
    ALUOp        = 2'b00;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    mem_err      = 1'b0;
    retire       = 1'b0;
    case (st_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        st_d    = S_DECODE;
      end
      S_DECODE: begin
        case (dec_cls)
          C_B: begin
            Uncondbranch = 1'b1;
            PCWrite      = 1'b1;
            retire       = 1'b1;
            st_d         = S_FETCH;
          end
          C_ILLEGAL: begin
`ifdef ILLEGAL_OP_TRAP_EN
            st_d = S_TRAP;
`else
            PCWrite = 1'b1;
            retire  = 1'b1;
            st_d    = S_FETCH;
`endif
          end
          default: st_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          C_LDUR, C_STUR: begin
            ALUSrc  = 1'b1;
            Reg2Loc = (cls_q == C_STUR);
            st_d    = S_MEM;
          end
          C_ADD, C_SUB, C_AND, C_ORR: begin
            ALUOp = 2'b10;
            st_d  = S_WB;
          end
          C_CBZ: begin
            Reg2Loc = 1'b1;
            ALUOp   = 2'b01;
            Branch  = 1'b1;
            PCWrite = 1'b1;
            retire  = 1'b1;
            st_d    = S_FETCH;
          end
          default: st_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if ((cls_q == C_LDUR) || (cls_q == C_STUR)) begin
          ALUSrc   = 1'b1;
          MemRead  = (cls_q == C_LDUR);
          MemWrite = (cls_q == C_STUR);
          // A ready response in the final wait cycle still completes normally.
          if (mem_ready) begin
            if (cls_q == C_LDUR) begin
              st_d = S_WB;
            end else begin
              PCWrite = 1'b1;
              retire  = 1'b1;
              st_d    = S_FETCH;
            end
          end else if (mem_last) begin
            // Abandon the access: advance the PC but do not count it as retired.
            mem_err = 1'b1;
            PCWrite = 1'b1;
            st_d    = S_FETCH;
          end else begin
            st_d = S_MEM;
          end
        end else begin
          st_d = S_FETCH;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        MemToReg = (cls_q == C_LDUR);
        retire   = 1'b1;
        st_d     = S_FETCH;
      end
      S_TRAP: begin
`ifdef ILLEGAL_OP_TRAP_EN
        st_d = S_TRAP;
`else
        st_d = S_FETCH;
`endif
      end
      default: st_d = S_FETCH;
    endcase
  end

endmodule
